// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the 8N1 UART receiver: FSM state encoding, default
//   bit timing for the 50 MHz / 9600 baud system and the mid-bit offset helper.
//   No ports; imported by uart_rx.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50_000_000 / 9600
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4,
        ST_BREAK   = 3'd5
    } rx_state_e;

    // Offset from the start-bit falling edge to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for a single asynchronous input. The reset value is a
//   parameter so an idle-high line does not look like activity on reset release.
// Ports:
//   clk_i    in  1  destination clock
//   rst_i    in  1  synchronous, active-high reset
//   async_i  in  1  asynchronous input
//   sync_o   out 1  synchronised copy of async_i (2-cycle latency)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. Synchronises the serial line, detects a start bit,
//   re-checks it at mid-bit and then samples each data bit and the stop bit one
//   bit period apart, i.e. at the middle of each bit. A good frame updates
//   o_Rx_Byte with a one-cycle o_Rx_DV strobe; a low stop bit gives a one-cycle
//   o_Rx_Frame_Err strobe and the receiver waits for the line to return high.
// Ports:
//   i_Clock         in  1  system clock
//   i_Reset         in  1  synchronous, active-high reset
//   i_Rx_Serial     in  1  asynchronous serial line, idle high, LSB first
//   o_Rx_DV         out 1  one-cycle strobe, o_Rx_Byte holds a new byte
//   o_Rx_Byte       out 8  last good byte, held until the next good frame
//   o_Rx_Busy       out 1  high from start-bit detect until back in IDLE
//   o_Rx_Frame_Err  out 1  one-cycle strobe, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Rx_Serial,
    output logic                      o_Rx_DV,
    output logic [UART_DATA_BITS-1:0] o_Rx_Byte,
    output logic                      o_Rx_Busy,
    output logic                      o_Rx_Frame_Err
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF     = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;

    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic [IDX_W-1:0]          idx_q,   idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_q,  byte_d;
    logic                      dv_q,    dv_d;
    logic                      err_q,   err_d;
    logic                      busy_q,  busy_d;

    // Reset to 1 so an idle-high line is not seen as a start bit on release.
    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (i_Clock),
        .rst_i   (i_Reset),
        .async_i (i_Rx_Serial),
        .sync_o  (rx_s)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned; a missing default here would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            // Re-check the line half a bit later; a high line means the low
            // level was a glitch and the frame is dropped silently.
            ST_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            // We are now at mid-bit, so one full bit period later is the
            // middle of the next bit.
            ST_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = ST_CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_CLEANUP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            // A held-low line would otherwise look like an endless stream of
            // start bits; wait for it to go high before re-arming.
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy is registered from the next state so it rises with START and falls
    // on the cycle the FSM re-enters IDLE.
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge i_Clock) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Busy      = busy_q;
    assign o_Rx_Frame_Err = err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx at 16 clocks per bit (HALF = 7). The serial
//   line is driven by a small transmitter model on the falling clock edge; a
//   monitor on the falling edge counts strobes and records received bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_Clock     = 1'b0;
    logic       i_Reset     = 1'b1;
    logic       i_Rx_Serial = 1'b1;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Busy;
    logic       o_Rx_Frame_Err;

    int errors = 0;
    int checks = 0;

    // Monitor state, written only by the monitor process.
    int         cyc       = 0;
    int         dv_cnt    = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         busy_rise = 0;
    int         dv_cyc    = 0;
    int         fall_cyc  = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Rx_Serial    (i_Rx_Serial),
        .o_Rx_DV        (o_Rx_DV),
        .o_Rx_Byte      (o_Rx_Byte),
        .o_Rx_Busy      (o_Rx_Busy),
        .o_Rx_Frame_Err (o_Rx_Frame_Err)
    );

    always #5 i_Clock = ~i_Clock;

    always @(negedge i_Clock) begin
        cyc = cyc + 1;
        if (o_Rx_DV === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            rx_q.push_back(o_Rx_Byte);
        end
        if (o_Rx_Frame_Err === 1'b1) err_cnt = err_cnt + 1;
        if (o_Rx_DV === 1'b1 && o_Rx_Frame_Err === 1'b1) both_cnt = both_cnt + 1;
        if (o_Rx_Busy === 1'b1 && busy_prev === 1'b0) busy_rise = busy_rise + 1;
        if (o_Rx_Busy === 1'b0 && busy_prev === 1'b1) fall_cyc = cyc;
        busy_prev = o_Rx_Busy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic drive_bit(input logic v, input int n);
        i_Rx_Serial = v;
        repeat (n) @(negedge i_Clock);
    endtask

    // p2 is the bit period in half clocks, so 32 is exactly 16 clocks per bit
    // and 31/33 model a transmitter running about 3% fast/slow.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p2);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drive_bit(bits[k], ((k + 1) * p2) / 2 - (k * p2) / 2);
        end
        i_Rx_Serial = 1'b1;
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    task automatic test_reset;
        i_Reset = 1'b1;
        idle(3);
        if (o_Rx_DV !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", o_Rx_DV); end
        checks++;
        if (o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", o_Rx_Byte); end
        checks++;
        if (o_Rx_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_Rx_Busy); end
        checks++;
        if (o_Rx_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_Rx_Frame_Err); end
        checks++;
        i_Reset = 1'b0;
        idle(10);
        if (busy_rise !== 0) begin errors++; $display("FAIL reset_release_start: busy rises %0d want 0", busy_rise); end
        checks++;
    endtask

    task automatic test_single;
        int dv0, e0, q0;
        dv0 = dv_cnt; e0 = err_cnt; q0 = rx_q.size();
        send_frame(8'h81, 1'b1, 2 * CPB);
        idle(40);
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
        checks++;
        if (rx_at(q0) !== 8'h81) begin errors++; $display("FAIL single_byte: got %h want 81", rx_at(q0)); end
        checks++;
        if (o_Rx_Byte !== 8'h81) begin errors++; $display("FAIL single_held: got %h want 81", o_Rx_Byte); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
        checks++;
        if (fall_cyc - dv_cyc < 1 || fall_cyc - dv_cyc > 2) begin
            errors++; $display("FAIL single_busy_drop: %0d cycles after DV want 1..2", fall_cyc - dv_cyc);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [4];
        int dv0, e0, q0;
        exp = '{8'h55, 8'hAA, 8'h00, 8'hFF};
        dv0 = dv_cnt; e0 = err_cnt; q0 = rx_q.size();
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1, 2 * CPB);
        idle(40);
        if (dv_cnt - dv0 !== 4) begin errors++; $display("FAIL b2b_dv_count: got %0d want 4", dv_cnt - dv0); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (rx_at(q0 + i) !== exp[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_at(q0 + i), exp[i]);
            end
            checks++;
        end
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
        checks++;
    endtask

    task automatic test_glitch;
        int dv0, e0, r0;
        dv0 = dv_cnt; e0 = err_cnt; r0 = busy_rise;
        drive_bit(1'b0, 4);
        i_Rx_Serial = 1'b1;
        idle(40);
        if (busy_rise - r0 !== 1) begin errors++; $display("FAIL glitch_busy_pulse: got %0d want 1", busy_rise - r0); end
        checks++;
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL glitch_dv: got %0d want 0", dv_cnt - dv0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
        checks++;
        if (o_Rx_Busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy %b want 0", o_Rx_Busy); end
        checks++;
    endtask

    task automatic test_break;
        int dv0, e0, q0;
        dv0 = dv_cnt; e0 = err_cnt; q0 = rx_q.size();
        send_frame(8'h3C, 1'b0, 2 * CPB);
        drive_bit(1'b0, 100);
        i_Rx_Serial = 1'b1;
        idle(40);
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_err_count: got %0d want 1", err_cnt - e0); end
        checks++;
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL break_dv: got %0d want 0", dv_cnt - dv0); end
        checks++;
        if (o_Rx_Byte !== 8'hFF) begin errors++; $display("FAIL break_byte_held: got %h want ff", o_Rx_Byte); end
        checks++;
        if (o_Rx_Busy !== 1'b0) begin errors++; $display("FAIL break_release: busy %b want 0", o_Rx_Busy); end
        checks++;
        send_frame(8'hA5, 1'b1, 2 * CPB);
        idle(40);
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL break_next_dv: got %0d want 1", dv_cnt - dv0); end
        checks++;
        if (rx_at(q0) !== 8'hA5) begin errors++; $display("FAIL break_next_byte: got %h want a5", rx_at(q0)); end
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_err_total: got %0d want 1", err_cnt - e0); end
        checks++;
    endtask

    // 0x7E LSB first: start 0, then 0,1,1,1,1 up to bit 4; reset mid bit 4 and
    // the transmitter abandons the frame along with the receiver.
    task automatic test_mid_reset;
        int dv0, e0, q0;
        dv0 = dv_cnt; e0 = err_cnt;
        drive_bit(1'b0, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, CPB / 2);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        if (o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h want 00", o_Rx_Byte); end
        checks++;
        if (o_Rx_Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_Rx_Busy); end
        checks++;
        if (o_Rx_DV !== 1'b0 || o_Rx_Frame_Err !== 1'b0) begin
            errors++; $display("FAIL midrst_strobes: dv %b err %b want 0 0", o_Rx_DV, o_Rx_Frame_Err);
        end
        checks++;
        idle(200);
        if (dv_cnt - dv0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL midrst_no_strobe: dv %0d err %0d want 0 0", dv_cnt - dv0, err_cnt - e0);
        end
        checks++;
        q0 = rx_q.size();
        send_frame(8'h7E, 1'b1, 2 * CPB);
        idle(40);
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midrst_next_dv: got %0d want 1", dv_cnt - dv0); end
        checks++;
        if (rx_at(q0) !== 8'h7E) begin errors++; $display("FAIL midrst_next_byte: got %h want 7e", rx_at(q0)); end
        checks++;
    endtask

    // A whole clock of mismatch per bit drifts 9 clocks by the stop bit, more
    // than HALF; half a clock per bit (4.5 clocks) stays inside the window.
    task automatic test_loopback;
        int dv0, e0, q0, n;
        int p2s [3];
        p2s = '{2 * CPB, 2 * CPB - 1, 2 * CPB + 1};
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? 256 : 24;
            dv0 = dv_cnt; e0 = err_cnt; q0 = rx_q.size();
            for (int i = 0; i < n; i++) send_frame(8'(i * 37 + 5 * r), 1'b1, p2s[r]);
            idle(40);
            if (dv_cnt - dv0 !== n) begin
                errors++; $display("FAIL loop%0d_dv_count: got %0d want %0d", r, dv_cnt - dv0, n);
            end
            checks++;
            for (int i = 0; i < n; i++) begin
                if (rx_at(q0 + i) !== 8'(i * 37 + 5 * r)) begin
                    errors++; $display("FAIL loop%0d_byte%0d: got %h want %h", r, i, rx_at(q0 + i), 8'(i * 37 + 5 * r));
                end
                checks++;
            end
            if (err_cnt - e0 !== 0) begin errors++; $display("FAIL loop%0d_err: got %0d want 0", r, err_cnt - e0); end
            checks++;
        end
    endtask

    task automatic test_exclusive;
        if (both_cnt !== 0) begin errors++; $display("FAIL dv_err_overlap: got %0d want 0", both_cnt); end
        checks++;
    endtask

    initial begin
        @(negedge i_Clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_mid_reset();
        test_loopback();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
